// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store bus adapter: size codes, FSM states,
// latched request payload and strobe/lane helpers.
package mem_access_unit_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] off;
  } mem_req_t;

  // Legal size code for the direction and naturally aligned for that size.
  function automatic logic access_ok(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] off);
    logic ok;
    case (funct3)
      F3_B, F3_BU: ok = !(we && funct3 == F3_BU);
      F3_H, F3_HU: ok = !off[0] && !(we && funct3 == F3_HU);
      F3_W:        ok = (off == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [STRB_W-1:0] strobe(input logic [2:0] funct3,
                                               input logic [1:0] off);
    logic [STRB_W-1:0] s;
    case (funct3[1:0])
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = 4'b0011 << off;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] lane(input logic [2:0] funct3,
                                             input logic [1:0] off,
                                             input logic [DATA_W-1:0] wdata);
    logic [DATA_W-1:0] d;
    if (funct3[1:0] == 2'b10) d = wdata;
    else                      d = wdata << {off, 3'b000};
    return d;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        off_i,
  input  logic [2:0]        funct3_i,
  output logic [DATA_W-1:0] result_c_o
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = word_i >> {off_i, 3'b000};
    case (funct3_i)
      F3_B:    result_c_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result_c_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   result_c_o = {24'd0, shifted[7:0]};
      F3_HU:   result_c_o = {16'd0, shifted[15:0]};
      default: result_c_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store bus adapter: one request becomes one word-aligned valid/ready
// transaction with byte strobes; load data is extended before being returned.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              bus_valid_o,
  input  logic              bus_ready_i,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic              bus_we_o,
  output logic [STRB_W-1:0] bus_wstrb_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  mem_req_t          req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_flag_q, err_flag_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              bus_valid_q, bus_valid_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              bus_we_q, bus_we_d;
  logic [STRB_W-1:0] bus_wstrb_q, bus_wstrb_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] ext_data;

  mem_access_unit_load_extend u_load_extend (
    .word_i     (bus_rdata_i),
    .off_i      (req_q.off),
    .funct3_i   (req_q.funct3),
    .result_c_o (ext_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      err_flag_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      err_flag_q  <= err_flag_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      bus_valid_q <= bus_valid_d;
      bus_addr_q  <= bus_addr_d;
      bus_we_q    <= bus_we_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    err_flag_d  = err_flag_q;
    rdata_d     = rdata_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          req_d = '{we: we_i, funct3: funct3_i, off: addr_i[1:0]};
          if (!access_ok(we_i, funct3_i, addr_i[1:0])) begin
            state_d    = ST_DONE;
            err_flag_d = 1'b1;
          end else begin
            state_d     = ST_REQ;
            err_flag_d  = 1'b0;
            cnt_d       = '0;
            bus_addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
            bus_wstrb_d = we_i ? strobe(funct3_i, addr_i[1:0]) : '0;
            bus_wdata_d = we_i ? lane(funct3_i, addr_i[1:0], wdata_i) : '0;
          end
        end
      end
      ST_REQ: begin
        if (bus_ready_i) begin
          state_d = req_q.we ? ST_DONE : ST_RESP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_DONE;
          err_flag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        // Read data is captured only here; a stray rvalid elsewhere is dropped.
        if (bus_rvalid_i) begin
          rdata_d = ext_data;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_DONE;
          err_flag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    err_d       = (state_d == ST_DONE) && err_flag_d;
    bus_valid_d = (state_d == ST_REQ);
    bus_we_d    = (state_d == ST_REQ) && req_d.we;
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign bus_valid_o = bus_valid_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_we_o    = bus_we_q;
  assign bus_wstrb_o = bus_wstrb_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads, error paths, timeout,
// back-to-back requests and reset during a read.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        bus_valid;
  logic        bus_ready = 1'b1;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  int total = 0;
  int bad = 0;

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .we_i         (we),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .rdata_o      (rdata),
    .bus_valid_o  (bus_valid),
    .bus_ready_i  (bus_ready),
    .bus_addr_o   (bus_addr),
    .bus_we_o     (bus_we),
    .bus_wstrb_o  (bus_wstrb),
    .bus_wdata_o  (bus_wdata),
    .bus_rvalid_i (bus_rvalid),
    .bus_rdata_i  (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
  endtask

  task automatic test_reset();
    step(); step();
    total++; if ({busy, done, err, bus_valid, bus_we} !== 5'b0) begin bad++;
      $display("FAIL reset_ctrl: got %b want 00000", {busy, done, err, bus_valid, bus_we}); end
    total++; if (bus_wstrb !== 4'h0) begin bad++;
      $display("FAIL reset_wstrb: got %h want 0", bus_wstrb); end
    total++; if ({rdata, bus_addr, bus_wdata} !== 96'h0) begin bad++;
      $display("FAIL reset_data: got %h %h %h want 0", rdata, bus_addr, bus_wdata); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_store_word();
    bus_ready = 1'b1;
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    step(); req = 1'b0;
    total++; if ({bus_valid, bus_we, busy, done} !== 4'b1110) begin bad++;
      $display("FAIL sw_req_ctrl: got %b want 1110", {bus_valid, bus_we, busy, done}); end
    total++; if (bus_wstrb !== 4'b1111 || bus_addr !== 32'h100 || bus_wdata !== 32'hDEADBEEF) begin bad++;
      $display("FAIL sw_bus: got %b %h %h want 1111 00000100 deadbeef", bus_wstrb, bus_addr, bus_wdata); end
    step();
    total++; if ({done, err} !== 2'b10) begin bad++;
      $display("FAIL sw_done_c2: got %b want 10", {done, err}); end
    step();
    total++; if ({done, busy, bus_valid} !== 3'b000) begin bad++;
      $display("FAIL sw_idle: got %b want 000", {done, busy, bus_valid}); end
  endtask

  task automatic test_store_byte();
    issue(1'b1, 3'b000, 32'h103, 32'h000000A5);
    step(); req = 1'b0;
    total++; if (bus_wstrb !== 4'b1000 || bus_addr !== 32'h100 || bus_wdata[31:24] !== 8'hA5) begin bad++;
      $display("FAIL sb_bus: got %b %h %h want 1000 00000100 a5xxxxxx", bus_wstrb, bus_addr, bus_wdata); end
    step();
    total++; if ({done, err} !== 2'b10) begin bad++;
      $display("FAIL sb_done: got %b want 10", {done, err}); end
    step();
  endtask

  task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] word, input logic [31:0] exp);
    bus_ready = 1'b1;
    issue(1'b0, f3, a, 32'h0);
    step(); req = 1'b0;
    total++; if ({bus_valid, bus_we, bus_wstrb} !== 6'b100000 || bus_addr !== {a[31:2], 2'b00}) begin bad++;
      $display("FAIL %s_req: got %b %h want 100000 %h", name, {bus_valid, bus_we, bus_wstrb}, bus_addr, {a[31:2], 2'b00}); end
    step();
    bus_rvalid = 1'b1; bus_rdata = word;
    step();
    bus_rvalid = 1'b0;
    total++; if ({done, err} !== 2'b10 || rdata !== exp) begin bad++;
      $display("FAIL %s_data: got done/err=%b rdata=%h want 10 %h", name, {done, err}, rdata, exp); end
    step();
  endtask

  task automatic test_misaligned();
    logic [31:0] prev;
    prev = rdata;
    issue(1'b0, 3'b010, 32'h102, 32'h0);
    step(); req = 1'b0;
    total++; if ({done, err, busy, bus_valid} !== 4'b1110) begin bad++;
      $display("FAIL lw_misaligned: got %b want 1110", {done, err, busy, bus_valid}); end
    step();
    total++; if ({done, busy, bus_valid} !== 3'b000 || rdata !== prev) begin bad++;
      $display("FAIL lw_misaligned_after: got %b rdata=%h want 000 %h", {done, busy, bus_valid}, rdata, prev); end
    issue(1'b1, 3'b100, 32'h100, 32'h1);
    step(); req = 1'b0;
    total++; if ({done, err, bus_valid} !== 3'b110) begin bad++;
      $display("FAIL sbu_illegal: got %b want 110", {done, err, bus_valid}); end
    step();
  endtask

  task automatic test_timeout();
    int vbad;
    vbad = 0;
    bus_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h200, 32'h0);
    step(); req = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (bus_valid !== 1'b1 || done !== 1'b0) vbad++;
      step();
    end
    total++; if (vbad !== 0) begin bad++;
      $display("FAIL timeout_wait: got %0d bad cycles want 0", vbad); end
    total++; if ({done, err, bus_valid} !== 3'b110 || rdata !== 32'h000012F4) begin bad++;
      $display("FAIL timeout_done: got %b rdata=%h want 110 000012f4", {done, err, bus_valid}, rdata); end
    step();
    bus_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 3'b010, 32'h100, 32'h1);
    step(); step();
    total++; if (done !== 1'b1) begin bad++;
      $display("FAIL b2b_first_done: got %b want 1", done); end
    addr = 32'h300;
    step();
    total++; if ({busy, bus_valid} !== 2'b00) begin bad++;
      $display("FAIL b2b_ignored: got %b want 00", {busy, bus_valid}); end
    step(); req = 1'b0;
    total++; if (bus_valid !== 1'b1 || bus_addr !== 32'h300) begin bad++;
      $display("FAIL b2b_second: got %b %h want 1 00000300", bus_valid, bus_addr); end
    step();
    total++; if (done !== 1'b1) begin bad++;
      $display("FAIL b2b_second_done: got %b want 1", done); end
    step();
  endtask

  task automatic test_reset_mid();
    int dcount;
    dcount = 0;
    issue(1'b0, 3'b010, 32'h104, 32'h0);
    step(); req = 1'b0;
    step();
    rst = 1'b1;
    #1;
    total++; if ({busy, done, bus_valid} !== 3'b000 || rdata !== 32'h0) begin bad++;
      $display("FAIL rst_mid_async: got %b rdata=%h want 000 0", {busy, done, bus_valid}, rdata); end
    step();
    rst = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'hCAFEBABE;
    step();
    bus_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (done !== 1'b0) dcount++;
      step();
    end
    total++; if (dcount !== 0 || rdata !== 32'h0 || busy !== 1'b0) begin bad++;
      $display("FAIL rst_mid_stray: got dones=%0d rdata=%h busy=%b want 0 0 0", dcount, rdata, busy); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_load("lb",  3'b000, 32'h102, 32'h12F45678, 32'hFFFFFFF4);
    test_load("lbu", 3'b100, 32'h102, 32'h12F45678, 32'h000000F4);
    test_load("lh",  3'b001, 32'h102, 32'h89AB0000, 32'hFFFF89AB);
    test_load("lw",  3'b010, 32'h108, 32'h0BADF00D, 32'h0BADF00D);
    test_load("lhu", 3'b101, 32'h102, 32'h12F45678, 32'h000012F4);
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
